mrc_result_bcd: RTL and testbench

Downstream result stage of the MRC datapath. Captures the `2*WORD_LENGTH`-bit result on the controller's one-cycle `ready` pulse and optionally takes its two's-complement magnitude. It then converts the magnitude to packed BCD with a sequential shift-add-3 (double-dabble) loop, one bit per clock. The BCD digits and sign feed the board's seven-segment display driver.

---
 rtl/mrc_result_bcd_pkg.sv | 22 ++
 rtl/mrc_result_bcd_digit_adjust.sv | 13 +
 rtl/mrc_result_bcd.sv | 154 +++++++++++++++
 tb/tb_mrc_result_bcd.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mrc_result_bcd_pkg.sv
// Shared definitions for the MRC result BCD stage.
//   state_t     : controller state encoding (IDLE=0, CONVERT=1, DONE=2).
//   RESULT_W    : result width for the default 16-bit MRC core (2*WORD_LENGTH).
//   min_digits  : smallest BCD digit count that can hold a 'width'-bit unsigned
//                 value, used by the top level for an elaboration-time check.
package mrc_result_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEFAULT_WORD_LENGTH = 16;
  localparam int RESULT_W            = 2 * DEFAULT_WORD_LENGTH;

  // ceil(width * log10(2)), with log10(2) approximated as 0.30103 in fixed point.
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/mrc_result_bcd_digit_adjust.sv
// Double-dabble digit correction: one packed BCD digit is bumped by 3 when it
// is 5 or more, so the following left shift carries correctly into the next
// digit.
//   d : input BCD digit (4 bits)
//   q : corrected digit (4 bits)
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/mrc_result_bcd.sv
// Result stage of the MRC datapath. Captures the 2*WORD_LENGTH-bit result on
// the controller's ready pulse, takes its magnitude when it is signed and
// negative, and converts it to packed BCD one bit per clock (double dabble).
//   clk       : clock
//   reset     : asynchronous, active-low reset
//   ready     : one-cycle pulse, result is valid
//   result    : result word (2*WORD_LENGTH bits)
//   signed_in : result is two's complement (sampled with ready)
//   bcd       : packed BCD, digit 0 in bits [3:0]
//   negative  : sign of the last converted value
//   busy      : conversion in progress (CONVERT or DONE)
//   valid     : one-cycle pulse when bcd/negative update
//   overrun   : sticky, a ready was dropped while busy
module mrc_result_bcd
  import mrc_result_bcd_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int DIGITS      = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic [2*WORD_LENGTH-1:0] result,
  input  logic                     signed_in,
  output logic [4*DIGITS-1:0]      bcd,
  output logic                     negative,
  output logic                     busy,
  output logic                     valid,
  output logic                     overrun
);

  localparam int RES_W = 2 * WORD_LENGTH;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(RES_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RES_W - 1);

  if (DIGITS < min_digits(RES_W)) begin : g_digits_too_small
    $error("mrc_result_bcd: DIGITS too small for a %0d-bit result", RES_W);
  end

  state_t state, state_next;

  logic [RES_W-1:0] sh;
  logic [BCD_W-1:0] wb;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic             load;
  logic             shift;
  logic             finish;

  logic             neg_in;
  logic [RES_W-1:0] mag;
  logic [BCD_W-1:0] wb_adj;
  logic [BCD_W-1:0] wb_shift;

  // Magnitude as an unsigned RES_W-bit value. The signed minimum negates to
  // itself, which is exactly its unsigned magnitude 2^(RES_W-1).
  assign neg_in = signed_in & result[RES_W-1];
  assign mag    = neg_in ? ((~result) + {{(RES_W-1){1'b0}}, 1'b1}) : result;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .d (wb[4*g +: 4]),
      .q (wb_adj[4*g +: 4])
    );
  end

  // Corrected digits shifted left by one, taking the next magnitude bit in.
  assign wb_shift = {wb_adj[BCD_W-2:0], sh[RES_W-1]};

  assign busy = (state != IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (ready) begin
          load       = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        shift = 1'b1;
        if (cnt == LAST_CNT) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: the working registers are reset along with the outputs so that a
  // reset mid-conversion leaves no stale partial result anywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh       <= '0;
      wb       <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      bcd      <= '0;
      negative <= 1'b0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid <= finish;

      if (load) begin
        overrun <= 1'b0;
      end else if (ready && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      if (load) begin
        sh  <= mag;
        wb  <= '0;
        cnt <= '0;
        neg <= neg_in;
      end else if (shift) begin
        sh  <= {sh[RES_W-2:0], 1'b0};
        wb  <= wb_shift;
        cnt <= cnt + 1'b1;
      end

      // Outputs change only on the final shift, so partial values never show.
      if (finish) begin
        bcd      <= wb_shift;
        negative <= neg;
      end
    end
  end

endmodule

// File: tb/tb_mrc_result_bcd.sv
// Self-checking bench for mrc_result_bcd (WORD_LENGTH=16, DIGITS=10).
// Accepted conversions push their expected BCD, sign and completion cycle to a
// scoreboard; a monitor pops and compares on every valid pulse.
module tb_mrc_result_bcd;

  localparam int W     = 16;
  localparam int RW    = 2 * W;
  localparam int DIG   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              ready;
  logic [RW-1:0]     result;
  logic              signed_in;
  logic [4*DIG-1:0]  bcd;
  logic              negative;
  logic              busy;
  logic              valid;
  logic              overrun;

  typedef struct {
    logic [4*DIG-1:0] bcd;
    logic             neg;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  mrc_result_bcd #(.WORD_LENGTH(W), .DIGITS(DIG)) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .result    (result),
    .signed_in (signed_in),
    .bcd       (bcd),
    .negative  (negative),
    .busy      (busy),
    .valid     (valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference conversion by repeated division, independent of double dabble.
  function automatic logic [4*DIG-1:0] bcd_of(input logic [RW-1:0] v);
    logic [4*DIG-1:0] r;
    longint           x;
    r = '0;
    x = longint'(v);
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", 64'(bcd), 64'(e.bcd));
        check("negative", 64'(negative), 64'(e.neg));
        check("latency", 64'(cyc), 64'(e.cyc));
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  // Drives one ready pulse; returns at the negedge right after the sampling
  // edge E0. Inputs are scrambled afterwards so only the ready cycle matters.
  task automatic send(input logic [RW-1:0] v, input logic s, input bit accept);
    logic          n;
    logic [RW-1:0] m;
    exp_t          e;
    @(negedge clk);
    ready     = 1'b1;
    result    = v;
    signed_in = s;
    @(negedge clk);
    ready     = 1'b0;
    result    = $urandom;
    signed_in = 1'($urandom_range(0, 1));
    if (accept) begin
      n     = s & v[RW-1];
      m     = n ? (RW'(0) - v) : v;
      e.bcd = bcd_of(m);
      e.neg = n;
      e.cyc = cyc + RW;
      sb.push_back(e);
      check("busy_rise", 64'(busy), 64'd1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    ready     = 1'b0;
    result    = '0;
    signed_in = 1'b0;
    #12;
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_negative", 64'(negative), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Unsigned conversions, including both ends of the range.
    send(32'd7006652, 1'b0, 1'b1);
    wait_idle();
    check("bcd_1234x5678", 64'(bcd), 64'h0007006652);
    send(32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_idle();
    check("bcd_umax", 64'(bcd), 64'h4294967295);
    send(32'd0, 1'b0, 1'b1);
    wait_idle();

    // Signed conversions, including -1, the signed minimum and zero.
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle();
    send(32'h8000_0000, 1'b1, 1'b1);
    wait_idle();
    check("bcd_smin", 64'(bcd), 64'h2147483648);
    check("neg_smin", 64'(negative), 64'd1);
    send(32'd0, 1'b1, 1'b1);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      send(32'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
    end

    // Back-to-back: second ready 10 cycles in is dropped and flags overrun.
    send(32'd123456789, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    send(32'd42, 1'b0, 1'b0);
    check("overrun_set", 64'(overrun), 64'd1);
    wait_idle();
    check("overrun_sticky", 64'(overrun), 64'd1);
    check("bcd_unchanged", 64'(bcd), 64'h0123456789);
    send(32'd31337, 1'b0, 1'b1);
    check("overrun_clear", 64'(overrun), 64'd0);
    wait_idle();

    // Throughput: readies exactly 2W+2 = 34 cycles apart are both accepted.
    send(32'd12345, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    check("bcd_first", 64'(bcd), 64'h0000012345);
    send(32'd999, 1'b0, 1'b1);
    check("overrun_tput", 64'(overrun), 64'd0);
    wait_idle();
    check("bcd_second", 64'(bcd), 64'h0000000999);
    check("overrun_tput_end", 64'(overrun), 64'd0);

    // Reset in the middle of a conversion, with overrun set beforehand.
    send(32'd555555, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    send(32'd1, 1'b0, 1'b0);
    check("overrun_pre_rst", 64'(overrun), 64'd1);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_negative", 64'(negative), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("no_valid_after_rst", 64'(bcd), 64'd0);
    send(32'hFFFF_FFFE, 1'b1, 1'b1);
    wait_idle();
    check("post_rst_bcd", 64'(bcd), 64'h0000000002);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
